// File: rtl/flp_sched_pkg.sv
// Shared definitions for shared-unit schedulers: FSM encoding, FP32 widths, tag sizing.
package flp_sched_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } sched_state_e;

  localparam int FP32_EWIDTH = 8;
  localparam int FP32_SWIDTH = 23;

  // Tag width for n requesters; never below 1 so a tag field always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/flp_rr_arb.sv
// Combinational round-robin arbiter: first request at or above ptr (mod NREQ) wins.
module flp_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any,
  output logic [IDW-1:0]  nxt_ptr
);

  always_comb begin
    logic [IDW:0] idx;
    gnt     = '0;
    gnt_id  = '0;
    any     = 1'b0;
    nxt_ptr = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (en && !any && req[idx[IDW-1:0]]) begin
        any                 = 1'b1;
        gnt[idx[IDW-1:0]]   = 1'b1;
        gnt_id              = idx[IDW-1:0];
        nxt_ptr             = (idx[IDW-1:0] == IDW'(NREQ-1)) ? '0 : idx[IDW-1:0] + IDW'(1);
      end
    end
  end

endmodule

// File: rtl/flp_add_sched.sv
// Round-robin scheduler sharing one LAT-cycle pipelined FP adder between NREQ requesters.
// Optional performance counters are enabled by defining FLP_ADD_SCHED_PERF_EN.
module flp_add_sched
  import flp_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int EWIDTH = FP32_EWIDTH,
  parameter int SWIDTH = FP32_SWIDTH,
  parameter int LAT    = 3,
  localparam int W     = 1 + EWIDTH + SWIDTH,
  localparam int IDW   = clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ-1:0][W-1:0]  i_req_a,
  input  logic [NREQ-1:0][W-1:0]  i_req_b,
  output logic [NREQ-1:0]         o_req_ready,
  output logic [W-1:0]            o_add_a,
  output logic [W-1:0]            o_add_b,
  output logic                    o_add_valid,
  input  logic [W-1:0]            i_add_p,
  output logic [NREQ-1:0]         o_res_valid,
  output logic [W-1:0]            o_res_p,
`ifdef FLP_ADD_SCHED_PERF_EN
  output logic [31:0]             o_perf_issued,
  output logic [31:0]             o_perf_stall,
`endif
  input  logic                    i_drain,
  output logic                    o_halted
);

  sched_state_e            state, state_nxt;
  logic [IDW-1:0]          ptr, ptr_nxt, gnt_id, add_id;
  logic                    gnt_any, arb_en, pipe_busy, res_vld;
  logic [LAT-1:0]          vld_pipe;
  logic [LAT-1:0][IDW-1:0] id_pipe;

  // Drain wins over a grant in the cycle it rises.
  assign arb_en = (state == RUN) && !i_drain && !rst;

  flp_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .en      (arb_en),
    .req     (i_req_valid),
    .ptr     (ptr),
    .gnt     (o_req_ready),
    .gnt_id  (gnt_id),
    .any     (gnt_any),
    .nxt_ptr (ptr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      o_add_valid <= 1'b0;
      o_add_a     <= '0;
      o_add_b     <= '0;
      add_id      <= '0;
    end else begin
      o_add_valid <= gnt_any;
      if (gnt_any) begin
        o_add_a <= i_req_a[gnt_id];
        o_add_b <= i_req_b[gnt_id];
        add_id  <= gnt_id;
        ptr     <= ptr_nxt;
      end
    end
  end

  // Tag shadow pipe tracks the adder with no backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= o_add_valid;
      id_pipe[0]  <= add_id;
      for (int s = 1; s < LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  assign res_vld = vld_pipe[LAT-1] && !rst;
  assign o_res_p = res_vld ? i_add_p : '0;

  for (genvar k = 0; k < NREQ; k++) begin : g_res
    assign o_res_valid[k] = res_vld && (id_pipe[LAT-1] == IDW'(k));
  end

  // Busy means something is still in flight after this cycle; the last stage retires now,
  // so HALT is reached the cycle after the final result.
  assign pipe_busy = o_add_valid || (|(vld_pipe << 1));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (i_drain) state_nxt = DRAIN;
      DRAIN:   if (!pipe_busy) state_nxt = i_drain ? HALT : RUN;
      HALT:    if (!i_drain) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign o_halted = (state == HALT) && !rst;

`ifdef FLP_ADD_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_issued <= '0;
      o_perf_stall  <= '0;
    end else begin
      if (gnt_any && !(&o_perf_issued)) o_perf_issued <= o_perf_issued + 32'd1;
      if ((|i_req_valid) && ((state != RUN) || i_drain) && !(&o_perf_stall))
        o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule
